// File: rtl/lfsr_seq_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_seq_pkg
// Shared types and constants for the LFSR burst sequencer and its stream stage.
//   seq_state_e      : sequencer FSM states (3-bit encoding)
//   STEP_MAX         : largest supported number of LFSR shifts per emitted word
//   CNT_W_DEFAULT    : default width of the burst length / word counter
//   step_cnt_width() : width needed for a down-counter that is loaded with 'step'
// -----------------------------------------------------------------------------
package lfsr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

  localparam int STEP_MAX      = 255;
  localparam int CNT_W_DEFAULT = 8;

  // The step counter is loaded with 'step' and counts down to 1, so it must
  // be able to hold the value 'step' itself.
  function automatic int step_cnt_width(input int step);
    return $clog2(step + 1);
  endfunction

endpackage

// File: rtl/lfsr_burst_sequencer_if.sv
// -----------------------------------------------------------------------------
// lfsr_burst_sequencer_if
// Valid/ready word stream carrying the pseudo-random words to a consumer.
//   Word_Out   : data word, held stable while Word_Valid=1 and Word_Ready=0
//   Word_Valid : word present
//   Word_Ready : consumer accepts the word at the next rising edge
// Modports: master (word producer), slave (word consumer).
// -----------------------------------------------------------------------------
interface lfsr_burst_sequencer_if #(
  parameter int Width = 16
);

  logic [Width-1:0] Word_Out;
  logic             Word_Valid;
  logic             Word_Ready;

  modport master (
    output Word_Out,
    output Word_Valid,
    input  Word_Ready
  );

  modport slave (
    input  Word_Out,
    input  Word_Valid,
    output Word_Ready
  );

endinterface

// File: rtl/lfsr_word_out_reg.sv
// -----------------------------------------------------------------------------
// lfsr_word_out_reg
// Output holding register for a valid/ready stream stage.
//   Clock     in  : rising-edge clock
//   sres      in  : synchronous active-high reset (word and valid to 0)
//   load      in  : capture load_data and raise valid
//   load_data in  : word to present
//   clear     in  : drop valid without a handshake (abort); word is kept
//   ready     in  : consumer ready
//   word      out : registered output word
//   valid     out : registered output valid
// Priority: sres > clear > load > handshake. With no event the word and valid
// simply hold, which is what keeps the output stable under backpressure.
// -----------------------------------------------------------------------------
module lfsr_word_out_reg #(
  parameter int Width = 16
) (
  input  logic             Clock,
  input  logic             sres,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             clear,
  input  logic             ready,
  output logic [Width-1:0] word,
  output logic             valid
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clock) begin
    if (sres) begin
      word  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      word  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_burst_sequencer.sv
// -----------------------------------------------------------------------------
// lfsr_burst_sequencer
// Controls an external LFSR (load / shift / seed) and emits a burst of
// Burst_Len words, each being the LFSR state after Step further shifts.
//   Clock         in  : rising-edge clock
//   sres          in  : synchronous active-high reset
//   Start         in  : start a burst (sampled only in IDLE)
//   Abort         in  : return to IDLE without Done (ignored in IDLE)
//   Seed          in  : seed, captured on an accepted Start
//   Burst_Len     in  : number of words, captured on an accepted Start
//   Lfsr_Q        in  : current LFSR state
//   Lfsr_ld_en    out : LFSR parallel load enable (LOAD state only)
//   Lfsr_shift_en out : LFSR shift enable (SHIFT state only)
//   Lfsr_Seed     out : LFSR load data (captured seed)
//   stream        if  : master side of the Word_Out/Word_Valid/Word_Ready stream
//   Busy          out : high in every state except IDLE
//   Done          out : one-cycle pulse after the last word is accepted
// Timing with Start sampled at edge k: LOAD in cycle k+1, SHIFT for Step
// cycles, CAPTURE, first Word_Valid in cycle k+Step+3; with Word_Ready held
// high one word every Step+2 cycles.
// -----------------------------------------------------------------------------
module lfsr_burst_sequencer
  import lfsr_seq_pkg::*;
#(
  parameter int Width = 16,
  parameter int Step  = 16,
  parameter int Cnt_W = CNT_W_DEFAULT
) (
  input  logic                  Clock,
  input  logic                  sres,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [Width-1:0]      Seed,
  input  logic [Cnt_W-1:0]      Burst_Len,
  input  logic [Width-1:0]      Lfsr_Q,
  output logic                  Lfsr_ld_en,
  output logic                  Lfsr_shift_en,
  output logic [Width-1:0]      Lfsr_Seed,
  lfsr_burst_sequencer_if.master stream,
  output logic                  Busy,
  output logic                  Done
);

  // Step is legal in 1..STEP_MAX; clamp so an out-of-range override still
  // yields a sane counter instead of a zero-width or wrapping one.
  localparam int StepC = (Step < 1) ? 1 : ((Step > STEP_MAX) ? STEP_MAX : Step);
  localparam int StepW = step_cnt_width(StepC);
  localparam logic [StepW-1:0] STEP_LOAD = StepW'(StepC);

  seq_state_e       state_q, state_d;
  logic [Width-1:0] seed_q;
  logic [Cnt_W-1:0] word_cnt_q;
  logic [StepW-1:0] step_cnt_q;

  logic handshake;
  logic abort_act;
  logic last_word;
  logic step_last;

  assign handshake = stream.Word_Valid && stream.Word_Ready;
  assign abort_act = Abort && (state_q != ST_IDLE);
  assign last_word = (word_cnt_q == Cnt_W'(1));
  assign step_last = (step_cnt_q == StepW'(1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (sres) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and LFSR enable decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    Lfsr_ld_en    = 1'b0;
    Lfsr_shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) state_d = (Burst_Len == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        Lfsr_ld_en = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        Lfsr_shift_en = 1'b1;
        if (step_last) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (handshake) state_d = last_word ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_act) state_d = ST_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Seed, word counter and step counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (sres) begin
      seed_q     <= '0;
      word_cnt_q <= '0;
      step_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (Start) begin
            seed_q     <= Seed;
            word_cnt_q <= Burst_Len;
          end
        end
        ST_LOAD: begin
          step_cnt_q <= STEP_LOAD;
        end
        ST_SHIFT: begin
          step_cnt_q <= step_cnt_q - 1'b1;
        end
        ST_PRESENT: begin
          // The counter leaves via DONE when it holds 1, so it never wraps
          // even for the maximum Burst_Len.
          if (handshake) begin
            word_cnt_q <= word_cnt_q - 1'b1;
            step_cnt_q <= STEP_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output word register: loads the LFSR state on the edge leaving CAPTURE
  // ---------------------------------------------------------------------------
  lfsr_word_out_reg #(
    .Width (Width)
  ) u_word_out_reg (
    .Clock     (Clock),
    .sres      (sres),
    .load      (state_q == ST_CAPTURE),
    .load_data (Lfsr_Q),
    .clear     (abort_act),
    .ready     (stream.Word_Ready),
    .word      (stream.Word_Out),
    .valid     (stream.Word_Valid)
  );

  assign Lfsr_Seed = seed_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_lfsr_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lfsr_burst_sequencer
// Width=8, Step=8 sequencer driving a bench 8-bit Galois LFSR
// (q = (q << 1) ^ (q[7] ? 8'h63 : 0)). From seed 0x01 successive 8-shift
// words are 0x63, 0xF3, 0x22.
// Cycle numbering: the stimulus drives Start while the cycle counter reads S;
// Start is sampled at the next edge ("edge 0") and spec cycle c is observed
// at the falling edge where the counter reads S+c.
// -----------------------------------------------------------------------------
module tb_lfsr_burst_sequencer;

  localparam int W    = 8;
  localparam int STEP = 8;
  localparam int CW   = 8;

  typedef struct {
    logic [W-1:0] word;
    int           cyc;
  } exp_word_t;

  logic          Clock = 1'b0;
  logic          sres  = 1'b1;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic [W-1:0]  Seed  = '0;
  logic [CW-1:0] Burst_Len = '0;
  logic [W-1:0]  lfsr_q = '0;
  logic          Lfsr_ld_en;
  logic          Lfsr_shift_en;
  logic [W-1:0]  Lfsr_Seed;
  logic          Busy;
  logic          Done;

  lfsr_burst_sequencer_if #(.Width(W)) stream_if ();

  lfsr_burst_sequencer #(
    .Width (W),
    .Step  (STEP),
    .Cnt_W (CW)
  ) dut (
    .Clock         (Clock),
    .sres          (sres),
    .Start         (Start),
    .Abort         (Abort),
    .Seed          (Seed),
    .Burst_Len     (Burst_Len),
    .Lfsr_Q        (lfsr_q),
    .Lfsr_ld_en    (Lfsr_ld_en),
    .Lfsr_shift_en (Lfsr_shift_en),
    .Lfsr_Seed     (Lfsr_Seed),
    .stream        (stream_if.master),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 Clock = ~Clock;

  // Bench LFSR; a zero state restarts at 0x01 when shifted.
  always @(posedge Clock) begin
    if (Lfsr_ld_en)
      lfsr_q <= Lfsr_Seed;
    else if (Lfsr_shift_en)
      lfsr_q <= (lfsr_q == '0) ? 8'h01 : ({lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h63 : 8'h00));
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_word_t exp_q[$];
  int        done_q[$];
  int        ld_log[$];
  int        sh_log[$];
  int        valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or Done.
  always @(negedge Clock) begin
    if (Lfsr_ld_en)    ld_log.push_back(cyc);
    if (Lfsr_shift_en) sh_log.push_back(cyc);
    if (stream_if.Word_Valid) valid_cycles++;
    if (Lfsr_ld_en && Lfsr_shift_en) begin
      n_checks++;
      n_fail++;
      $display("FAIL enables_exclusive: ld_en and shift_en both high at cycle %0d", cyc);
    end
    if (stream_if.Word_Valid && stream_if.Word_Ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h at cycle %0d, expected none", stream_if.Word_Out, cyc);
      end else begin
        exp_word_t e;
        e = exp_q.pop_front();
        check("word_data", stream_if.Word_Out, e.word);
        check("word_cycle", cyc, e.cyc);
      end
    end
    if (Done) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: Done high at cycle %0d, expected none", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic start_burst(input logic [W-1:0] s, input logic [CW-1:0] len);
    Seed      = s;
    Burst_Len = len;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] w, input int c);
    exp_word_t e;
    e.word = w;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
  endtask

  int s;

  initial begin
    stream_if.Word_Ready = 1'b1;

    // Reset values
    repeat (3) tick();
    check("rst_ld_en", Lfsr_ld_en, 0);
    check("rst_shift_en", Lfsr_shift_en, 0);
    check("rst_valid", stream_if.Word_Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_word_out", stream_if.Word_Out, 0);
    check("rst_seed", Lfsr_Seed, 0);
    sres = 1'b0;
    tick();

    // Test 1: single word, latency and enable timing
    ld_log.delete();
    sh_log.delete();
    s = cyc;
    push_word(8'h63, s + 11);
    done_q.push_back(s + 12);
    start_burst(8'h01, 8'd1);
    check("t1_seed_out", Lfsr_Seed, 8'h01);
    wait_until(s + 12);
    check("t1_busy_in_done", Busy, 1);
    wait_until(s + 13);
    check("t1_busy_low", Busy, 0);
    check("t1_ld_count", ld_log.size(), 1);
    if (ld_log.size() == 1) check("t1_ld_cycle", ld_log[0], s + 1);
    check("t1_sh_count", sh_log.size(), STEP);
    if (sh_log.size() == STEP) begin
      check("t1_sh_first", sh_log[0], s + 2);
      check("t1_sh_last", sh_log[STEP-1], s + 9);
    end
    wait_until(s + 15);
    check_drained("t1");

    // Test 2: three words, 10 cycles apart; Start while busy is ignored
    s = cyc;
    push_word(8'h63, s + 11);
    push_word(8'hF3, s + 21);
    push_word(8'h22, s + 31);
    done_q.push_back(s + 32);
    start_burst(8'h01, 8'd3);
    wait_until(s + 15);
    start_burst(8'hAA, 8'd0);
    wait_until(s + 25);
    start_burst(8'h55, 8'd7);
    check("t2_seed_kept", Lfsr_Seed, 8'h01);
    wait_until(s + 35);
    check("t2_idle", Busy, 0);
    check_drained("t2");

    // Test 3: five cycles of backpressure on the first word
    stream_if.Word_Ready = 1'b0;
    sh_log.delete();
    s = cyc;
    push_word(8'h63, s + 16);
    push_word(8'hF3, s + 26);
    done_q.push_back(s + 27);
    start_burst(8'h01, 8'd2);
    wait_until(s + 11);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", stream_if.Word_Valid, 1);
      check("t3_stall_word", stream_if.Word_Out, 8'h63);
      check("t3_stall_no_shift", Lfsr_shift_en, 0);
      tick();
    end
    stream_if.Word_Ready = 1'b1;
    wait_until(s + 30);
    check("t3_shift_total", sh_log.size(), 2 * STEP);
    check_drained("t3");

    // Test 4: zero-length burst
    ld_log.delete();
    sh_log.delete();
    valid_cycles = 0;
    s = cyc;
    done_q.push_back(s + 1);
    start_burst(8'h01, 8'd0);
    wait_until(s + 5);
    check("t4_no_ld", ld_log.size(), 0);
    check("t4_no_shift", sh_log.size(), 0);
    check("t4_no_valid", valid_cycles, 0);
    check_drained("t4");

    // Test 5: abort while shifting the second word, then restart
    s = cyc;
    push_word(8'h63, s + 11);
    start_burst(8'h01, 8'd4);
    wait_until(s + 15);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("t5_abort_idle", Busy, 0);
    check("t5_abort_valid", stream_if.Word_Valid, 0);
    wait_until(s + 22);
    check_drained("t5a");
    s = cyc;
    push_word(8'h63, s + 11);
    done_q.push_back(s + 12);
    start_burst(8'h01, 8'd1);
    wait_until(s + 15);
    check_drained("t5b");

    // Test 6: sres while presenting a word
    stream_if.Word_Ready = 1'b0;
    s = cyc;
    start_burst(8'h01, 8'd2);
    wait_until(s + 12);
    check("t6_presenting", stream_if.Word_Valid, 1);
    sres = 1'b1;
    tick();
    check("t6_rst_valid", stream_if.Word_Valid, 0);
    check("t6_rst_word", stream_if.Word_Out, 0);
    check("t6_rst_seed", Lfsr_Seed, 0);
    check("t6_rst_busy", Busy, 0);
    check("t6_rst_done", Done, 0);
    check("t6_rst_ld", Lfsr_ld_en, 0);
    check("t6_rst_shift", Lfsr_shift_en, 0);
    sres = 1'b0;
    stream_if.Word_Ready = 1'b1;
    repeat (4) tick();
    check("t6_stays_idle", Busy, 0);
    check_drained("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
